seq_det_moore: RTL and testbench

Parametrised Moore-type serial pattern detector. It is the generalised successor to the fixed 3-bit, 4-state sequence detector. It supports:
- a pattern of any length, compile-time selectable;
- runtime overlap or non-overlap matching;
- an input-valid qualifier;
- an optional saturating match counter.

It sits on a 1-bit serial data stream and flags, one cycle after the final bit, that the full pattern has been received.

---
 rtl/seq_det_pkg.sv | 36 +++
 rtl/seq_det_moore_if.sv | 43 ++++
 rtl/sat_cnt.sv | 19 +
 rtl/seq_det_moore.sv | 88 ++++++++
 tb/tb_seq_det_moore.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, limits and helper functions for the serial pattern detector.
package seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    function automatic int sw_f(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // True when the newest k bits of hist_x (bit 0 = newest) equal the
    // first k bits of the pattern (pattern MSB is received first).
    function automatic logic pfx_match(
        input logic [PAT_W_MAX:0]   hist_x,
        input logic [PAT_W_MAX-1:0] pattern,
        input int                   k,
        input int                   pat_w
    );
        logic ok;
        int   idx;
        ok = 1'b1;
        for (int i = 0; i < PAT_W_MAX; i++) begin
            idx = pat_w - k + i;
            if (i < k && hist_x[i[4:0]] != pattern[idx[3:0]]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_det_moore_if.sv
// Serial-stream bundle for seq_det_moore; match_cnt exists only with SEQ_DET_COUNT_EN.
interface seq_det_moore_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    import seq_det_pkg::*;

    localparam int SW = sw_f(PAT_W);

    logic          en;
    logic          x;
    logic          ovl;
    logic          z;
    logic [SW-1:0] y;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    modport master (
        output en,
        output x,
        output ovl,
        input  z,
        input  y
`ifdef SEQ_DET_COUNT_EN
        ,
        input  match_cnt
`endif
    );

    modport slave (
        input  en,
        input  x,
        input  ovl,
        output z,
        output y
`ifdef SEQ_DET_COUNT_EN
        ,
        output match_cnt
`endif
    );

endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && cnt != {W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_moore.sv
// Parametrised Moore serial pattern detector with runtime overlap control.
// Optional saturating match counter compiled in with SEQ_DET_COUNT_EN.
module seq_det_moore
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter int               CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    seq_det_moore_if.slave   bus
);

    localparam int                   SW      = sw_f(PAT_W);
    localparam logic [SW-1:0]        Y_MATCH = SW'(PAT_W);
    localparam logic [PAT_W_MAX-1:0] PAT_EXT = PAT_W_MAX'(PATTERN);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX || CNT_W < 1) begin : g_bad_param
        $error("seq_det_moore: PAT_W or CNT_W out of range");
    end

    logic [SW-1:0]      y, y_nxt;
    logic [PAT_W-1:0]   hist, hist_nxt;
    logic [SW-1:0]      hlen, hlen_nxt;
    logic [PAT_W_MAX:0] hx;
    int                 lim;
    int                 k_hit;
    ovl_mode_e          mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= '0;
            hist <= '0;
            hlen <= '0;
        end else begin
            y    <= y_nxt;
            hist <= hist_nxt;
            hlen <= hlen_nxt;
        end
    end

    // Longest pattern prefix that ends on the incoming bit, limited to the
    // bits actually received since reset or the last non-overlapping match.
    always_comb begin
        hx            = '0;
        hx[PAT_W:0]   = {hist, bus.x};
        lim           = (int'(hlen) < PAT_W) ? int'(hlen) + 1 : PAT_W;
        k_hit         = 0;
        for (int k = PAT_W; k >= 1; k--) begin
            if (k_hit == 0 && k <= lim && pfx_match(hx, PAT_EXT, k, PAT_W)) begin
                k_hit = k;
            end
        end

        mode     = ovl_mode_e'(bus.ovl);
        y_nxt    = y;
        hist_nxt = hist;
        hlen_nxt = hlen;
        if (bus.en) begin
            y_nxt    = SW'(k_hit);
            hist_nxt = {hist[PAT_W-2:0], bus.x};
            if (y_nxt == Y_MATCH && mode == OVL_OFF) begin
                hlen_nxt = '0;
            end else if (hlen != Y_MATCH) begin
                hlen_nxt = hlen + 1'b1;
            end
        end
    end

    assign bus.y = y;
    assign bus.z = (y == Y_MATCH);

`ifdef SEQ_DET_COUNT_EN
    logic hit;
    assign hit = bus.en && (k_hit == PAT_W);

    sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .cnt (bus.match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_det_moore.sv
// Four detector configurations share one serial stream; a queue-based
// suffix/prefix model predicts y, z and match_cnt for each every cycle.
module tb_seq_det_moore;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic x   = 1'b0;
    logic ovl = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_det_moore_if #(.PAT_W(3),  .CNT_W(8)) i0 ();
    seq_det_moore_if #(.PAT_W(3),  .CNT_W(8)) i1 ();
    seq_det_moore_if #(.PAT_W(2),  .CNT_W(2)) i2 ();
    seq_det_moore_if #(.PAT_W(16), .CNT_W(8)) i3 ();

    assign i0.en = en;  assign i0.x = x;  assign i0.ovl = ovl;
    assign i1.en = en;  assign i1.x = x;  assign i1.ovl = ovl;
    assign i2.en = en;  assign i2.x = x;  assign i2.ovl = ovl;
    assign i3.en = en;  assign i3.x = x;  assign i3.ovl = ovl;

    seq_det_moore #(.PAT_W(3),  .PATTERN(3'b110),    .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    seq_det_moore #(.PAT_W(3),  .PATTERN(3'b111),    .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    seq_det_moore #(.PAT_W(2),  .PATTERN(2'b10),     .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
    seq_det_moore #(.PAT_W(16), .PATTERN(16'hA5C3),  .CNT_W(8)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));

    // Reference model: raw received bits per detector, longest suffix that is a pattern prefix.
    int          mw[4]   = '{3, 3, 2, 16};
    logic [15:0] mp[4]   = '{16'h0006, 16'h0007, 16'h0002, 16'hA5C3};
    int          mmax[4] = '{255, 255, 3, 255};
    int          my[4];
    int          mc[4];
    bit          mq[4][$];

    function automatic int best(input int d);
        int  n;
        int  res;
        bit  ok;
        n   = mq[d].size();
        res = 0;
        for (int k = n; k >= 1; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (mq[d][n - k + j] != mp[d][mw[d] - 1 - j]) ok = 1'b0;
            end
            if (ok && res == 0) res = k;
        end
        return res;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit xi, input bit o);
        for (int d = 0; d < 4; d++) begin
            if (r) begin
                mq[d].delete();
                my[d] = 0;
                mc[d] = 0;
            end else if (e) begin
                mq[d].push_back(xi);
                while (mq[d].size() > mw[d]) void'(mq[d].pop_front());
                my[d] = best(d);
                if (my[d] == mw[d]) begin
                    if (mc[d] < mmax[d]) mc[d]++;
                    if (!o) mq[d].delete();
                end
            end
        end
    endtask

    task automatic check_all();
        int yo[4];
        int zo[4];
        yo[0] = int'(i0.y); yo[1] = int'(i1.y); yo[2] = int'(i2.y); yo[3] = int'(i3.y);
        zo[0] = int'(i0.z); zo[1] = int'(i1.z); zo[2] = int'(i2.z); zo[3] = int'(i3.z);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("model_y%0d", d), yo[d], my[d]);
            chk($sformatf("model_z%0d", d), zo[d], int'(my[d] == mw[d]));
        end
`ifdef SEQ_DET_COUNT_EN
        chk("model_cnt0", int'(i0.match_cnt), mc[0]);
        chk("model_cnt1", int'(i1.match_cnt), mc[1]);
        chk("model_cnt2", int'(i2.match_cnt), mc[2]);
        chk("model_cnt3", int'(i3.match_cnt), mc[3]);
`endif
    endtask

    task automatic step(input bit r, input bit e, input bit xi, input bit o);
        rst = r;
        en  = e;
        x   = xi;
        ovl = o;
        @(posedge clk);
        model_update(r, e, xi, o);
        #1;
        check_all();
    endtask

    initial begin
        logic [14:0] s1;
        logic [14:0] zm15;
        logic [9:0]  ys;
        logic [4:0]  zm5;
        logic [22:0] st;
        int          zc;
        int          ylast[2];

        // Reset state
        step(1, 1, 1, 1);
        chk("reset_y", int'(i0.y), 0);
        chk("reset_z", int'(i0.z), 0);

        // Default pattern 110, non-overlap
        s1   = 15'b011000111010110;
        zm15 = '0;
        ys   = '0;
        for (int i = 0; i < 15; i++) begin
            step(0, 1, s1[14 - i], 0);
            zm15 = {zm15[13:0], i0.z};
            if (i < 5) ys = {ys[7:0], i0.y};
        end
        chk("t1_zmask", int'(zm15), int'(15'b000100000100001));
        chk("t1_yseq",  int'(ys),   int'(10'b0001101100));
`ifdef SEQ_DET_COUNT_EN
        chk("t1_cnt", int'(i0.match_cnt), 3);
`endif

        // 111 with overlap, then without
        step(1, 0, 0, 0);
        zm5 = '0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 1);
            zm5 = {zm5[3:0], i1.z};
        end
        chk("t2_ovl_zmask", int'(zm5), int'(5'b00111));
`ifdef SEQ_DET_COUNT_EN
        chk("t2_ovl_cnt", int'(i1.match_cnt), 3);
`endif
        step(1, 0, 0, 0);
        zm5 = '0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0);
            zm5 = {zm5[3:0], i1.z};
            if (i >= 3) ylast[i - 3] = int'(i1.y);
        end
        chk("t2_novl_zmask", int'(zm5), int'(5'b00100));
        chk("t2_novl_y4", ylast[0], 1);
        chk("t2_novl_y5", ylast[1], 2);
`ifdef SEQ_DET_COUNT_EN
        chk("t2_novl_cnt", int'(i1.match_cnt), 1);
`endif

        // Stall mid-pattern and in MATCH
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, i[0], 0);
            chk("t3_stall_y", int'(i0.y), 2);
        end
        step(0, 1, 0, 0);
        chk("t3_match_z", int'(i0.z), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1'($urandom), 1'($urandom));
            chk("t3_hold_z", int'(i0.z), 1);
`ifdef SEQ_DET_COUNT_EN
            chk("t3_hold_cnt", int'(i0.match_cnt), 1);
`endif
        end

        // Reset mid-pattern
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("t4_pre_y", int'(i0.y), 2);
        step(1, 1, 0, 0);
        chk("t4_rst_y", int'(i0.y), 0);
        chk("t4_rst_z", int'(i0.z), 0);
`ifdef SEQ_DET_COUNT_EN
        chk("t4_rst_cnt", int'(i0.match_cnt), 0);
`endif
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("t4_mid_z", int'(i0.z), 0);
        step(0, 1, 0, 0);
        chk("t4_post_z", int'(i0.z), 1);

        // Counter saturation with a 2-bit counter
        step(1, 0, 0, 0);
        zc = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0);
            step(0, 1, 0, 0);
            zc += int'(i2.z);
`ifdef SEQ_DET_COUNT_EN
            chk("t5_cnt", int'(i2.match_cnt), (i + 1 < 3) ? i + 1 : 3);
`endif
        end
        chk("t5_zpulses", zc, 6);

        // 16-bit pattern after a random preamble, then with the last bit flipped
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 0, 0, 0);
            st        = '0;
            st[22:16] = 7'($urandom);
            st[15:0]  = 16'hA5C3;
            if (pass == 1) st[0] = ~st[0];
            zc = 0;
            for (int i = 0; i < 23; i++) begin
                step(0, 1, st[22 - i], 0);
                zc += int'(i3.z);
            end
            chk($sformatf("t6_z_last_p%0d", pass), int'(i3.z), (pass == 0) ? 1 : 0);
            chk($sformatf("t6_zcount_p%0d", pass), zc, (pass == 0) ? 1 : 0);
        end

        // Random traffic against the model
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
